mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, sets the data and address width.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 if_req  in  1  fetch request; held high until if_ack.
REQ-005 if_addr  in  XLEN  fetch address; stable while if_req is high.
REQ-006 if_rdata  out  XLEN  fetch read data; valid while if_ack is high.
REQ-007 if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 lsu_re / lsu_we  in  1 each  LSU read and write requests; held high until lsu_ack.
REQ-009 lsu_addr, lsu_wdata  in  XLEN each  LSU address and store data; stable while a request is high.
REQ-010 lsu_funct3  in  3  LSU access size and sign code.
REQ-011 lsu_rdata  out  XLEN  LSU load data; valid while lsu_ack is high.
REQ-012 lsu_ack  out  1  one-cycle LSU completion pulse.
REQ-013 mem_req, mem_we  out  1 each  shared memory bus request and write enable.
REQ-014 mem_addr, mem_wdata  out  XLEN each  bus address and write data.
REQ-015 mem_funct3  out  3  bus access code.
REQ-016 mem_rdata  in  XLEN  bus read data; valid when mem_ack is high.
REQ-017 mem_ack  in  1  one-cycle bus completion.
REQ-018 stall_F, stall_M  out  1 each  pipeline stalls for fetch and memory stages.

Function
REQ-019 The state machine SHALL have four states: IDLE, BUS_IF, BUS_LSU and RESP.
REQ-020 A pending LSU request SHALL mean lsu_re | lsu_we.
REQ-021 In IDLE with exactly one pending requester, the arbiter SHALL grant that requester on the next edge.
REQ-022 In IDLE with both requesters pending, the arbiter SHALL grant the requester not recorded in last_grant, then update last_grant.
REQ-023 On a grant, the arbiter SHALL register the requester's request fields into the mem_* outputs.
  - Fetch grant: mem_we=0, mem_funct3=3'b010.
  - LSU grant: mem_we=lsu_we; lsu_we wins if both lsu_re and lsu_we are high.
REQ-024 mem_req SHALL be high exactly while the state is BUS_IF or BUS_LSU, starting the cycle after the grant.
REQ-025 The mem_* outputs SHALL stay constant while mem_req is high.
REQ-026 In BUS_x with mem_ack=1, the arbiter SHALL move to RESP, capture mem_rdata, and route it to the granted requester.
REQ-027 In RESP, the granted requester's ack SHALL be high for exactly one cycle.
  - rdata SHALL hold its value until that requester's next ack.
  - The arbiter SHALL then return to IDLE.
REQ-028 No grant SHALL be made in RESP, so a request still held during its ack cycle is never re-granted.
REQ-029 mem_ack SHALL be ignored in IDLE and RESP.
REQ-030 Minimum latency from request to ack SHALL be 3 cycles.
  - Grant edge, then mem_req cycle with mem_ack, then RESP ack cycle.
  - A request rising at cycle 0 with mem_ack at cycle 1 gives ack at cycle 2.
REQ-031 The arbiter SHALL impose no timeout; mem_req stays high until mem_ack.
REQ-032 Stalls SHALL be combinational: stall_F = if_req & ~if_ack; stall_M = (lsu_re | lsu_we) & ~lsu_ack.
REQ-033 The arbiter SHALL guarantee at most one outstanding bus transaction at any time.

Reset
REQ-034 While reset_n is low at a posedge, the following SHALL be forced:
  - state = IDLE, last_grant = IF.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_funct3 = 0.
  - if_ack = 0, lsu_ack = 0, if_rdata = 0, lsu_rdata = 0.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no ack to either requester.
  - A late mem_ack after reset SHALL have no effect.
REQ-036 Because last_grant resets to IF, the first simultaneous request after reset SHALL be granted to the LSU.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
  - Single fetch: if_req=1, if_addr=0x100; memory acks on the first mem_req cycle with 0x00000013 -> mem_req for 1 cycle; if_ack at cycle 2 with if_rdata=0x13.
  - Tie after reset: if_req and lsu_re both rise at cycle 0 -> LSU is served first; fetch is granted in the IDLE cycle after the LSU RESP.
  - Alternation: both requesters held high continuously -> grants alternate LSU, IF, LSU, IF; neither requester is granted twice in a row.
  - Store with wait states: lsu_we=1, lsu_addr=0x2000, lsu_wdata=0xDEADBEEF, lsu_funct3=3'b010, mem_ack delayed 4 cycles -> mem_req high 5 cycles with mem_we=1 and fields constant; stall_M high until the lsu_ack cycle.
  - Reset mid-transaction: reset_n low for 1 cycle in BUS_LSU -> mem_req=0 and no lsu_ack; a mem_ack in the following cycle is ignored.
  - Held request: if_req kept high through its ack cycle -> no re-grant in RESP; a new grant in the next IDLE cycle starts a new transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the instruction fetch port and
// the load/store unit. One bus transaction at a time; on simultaneous requests
// the requester that did not win last time is granted. Completion is returned
// as a one-cycle ack with read data held until that requester's next ack.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  // fetch port
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  // load/store port
  input  logic            lsu_re,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [2:0]      lsu_funct3,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_ack,
  // shared memory bus
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  // pipeline stalls
  output logic            stall_F,
  output logic            stall_M
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUS_IF  = 2'd1;
  localparam logic [1:0] BUS_LSU = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  // fetch always reads a full word
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  logic [1:0]      state_reg, state_next;
  logic            last_grant_reg, last_grant_next;
  logic            mem_req_reg, mem_req_next;
  logic            mem_we_reg, mem_we_next;
  logic [XLEN-1:0] mem_addr_reg, mem_addr_next;
  logic [XLEN-1:0] mem_wdata_reg, mem_wdata_next;
  logic [2:0]      mem_funct3_reg, mem_funct3_next;
  logic            if_ack_reg, if_ack_next;
  logic            lsu_ack_reg, lsu_ack_next;
  logic [XLEN-1:0] if_rdata_reg, if_rdata_next;
  logic [XLEN-1:0] lsu_rdata_reg, lsu_rdata_next;

  logic if_pend;
  logic lsu_pend;
  logic pick_lsu;

  assign if_pend  = if_req;
  assign lsu_pend = lsu_re | lsu_we;
  // LSU wins when alone, or on a tie when fetch was served last
  assign pick_lsu = lsu_pend & (~if_pend | (last_grant_reg == GRANT_IF));

  // next-state, grant and response capture
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_funct3_next = mem_funct3_reg;
    if_ack_next     = 1'b0;
    lsu_ack_next    = 1'b0;
    if_rdata_next   = if_rdata_reg;
    lsu_rdata_next  = lsu_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (if_pend | lsu_pend) begin
          mem_req_next = 1'b1;
          if (pick_lsu) begin
            state_next      = BUS_LSU;
            last_grant_next = GRANT_LSU;
            mem_we_next     = lsu_we;
            mem_addr_next   = lsu_addr;
            mem_wdata_next  = lsu_wdata;
            mem_funct3_next = lsu_funct3;
          end else begin
            state_next      = BUS_IF;
            last_grant_next = GRANT_IF;
            mem_we_next     = 1'b0;
            mem_addr_next   = if_addr;
            mem_wdata_next  = '0;
            mem_funct3_next = FUNCT3_WORD;
          end
        end
      end
      BUS_IF: begin
        if (mem_ack) begin
          state_next    = RESP;
          mem_req_next  = 1'b0;
          if_ack_next   = 1'b1;
          if_rdata_next = mem_rdata;
        end
      end
      BUS_LSU: begin
        if (mem_ack) begin
          state_next     = RESP;
          mem_req_next   = 1'b0;
          lsu_ack_next   = 1'b1;
          lsu_rdata_next = mem_rdata;
        end
      end
      // ack cycle: no grant here, so a request still held is not re-served
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_IF;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_funct3_reg <= 3'b000;
      if_ack_reg     <= 1'b0;
      lsu_ack_reg    <= 1'b0;
      if_rdata_reg   <= '0;
      lsu_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_funct3_reg <= mem_funct3_next;
      if_ack_reg     <= if_ack_next;
      lsu_ack_reg    <= lsu_ack_next;
      if_rdata_reg   <= if_rdata_next;
      lsu_rdata_reg  <= lsu_rdata_next;
    end
  end

  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_funct3 = mem_funct3_reg;
  assign if_ack     = if_ack_reg;
  assign lsu_ack    = lsu_ack_reg;
  assign if_rdata   = if_rdata_reg;
  assign lsu_rdata  = lsu_rdata_reg;

  // stalls drop in the ack cycle so the stage advances with its data
  assign stall_F = if_req & ~if_ack_reg;
  assign stall_M = lsu_pend & ~lsu_ack_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a wait-state memory model answers the bus,
// and expected completions are queued when requests are driven.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_ack;
  logic            lsu_re, lsu_we;
  logic [XLEN-1:0] lsu_addr, lsu_wdata;
  logic [2:0]      lsu_funct3;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_ack;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_rdata = '1;
  logic            model_ack = 1'b0;
  logic            stray_ack = 1'b0;
  wire             mem_ack;
  logic            stall_F, stall_M;

  assign mem_ack = model_ack | stray_ack;

  typedef struct packed {
    logic            is_lsu;
    logic [XLEN-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mem_wait = 0;
  int   wcnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .lsu_re(lsu_re), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_funct3(lsu_funct3), .lsu_rdata(lsu_rdata), .lsu_ack(lsu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_F(stall_F), .stall_M(stall_M)
  );

  function automatic logic [XLEN-1:0] model_rdata(input logic [XLEN-1:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  // memory model: acks after mem_wait cycles of mem_req, data garbage otherwise
  always @(negedge clk) begin
    if (mem_req && !model_ack) begin
      if (wcnt >= mem_wait) begin
        model_ack = 1'b1;
        mem_rdata = model_rdata(mem_addr);
        wcnt = 0;
      end else begin
        wcnt = wcnt + 1;
        mem_rdata = '1;
      end
    end else begin
      model_ack = 1'b0;
      mem_rdata = '1;
      if (!mem_req) wcnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; lsu_re = 1'b0; lsu_we = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_funct3 = 3'b000; stray_ack = 1'b0; mem_wait = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; lsu_re = 1'b0; lsu_we = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_funct3 = 3'b000;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (mem_funct3 !== 3'b000) begin n_bad++; $display("FAIL reset_mem_funct3 got %b want 000", mem_funct3); end
    n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL reset_if_ack got %b want 0", if_ack); end
    n_cmp++; if (lsu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_lsu_ack got %b want 0", lsu_ack); end
    n_cmp++; if (if_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_if_rdata got %h want 0", if_rdata); end
    n_cmp++; if (lsu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_lsu_rdata got %h want 0", lsu_rdata); end
    if_req = 1'b1; lsu_we = 1'b1;
    #1;
    n_cmp++; if ({stall_F, stall_M} !== 2'b11) begin n_bad++; $display("FAIL reset_stalls got %b want 11", {stall_F, stall_M}); end
    if_req = 1'b0; lsu_we = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_idle_mem_req got %b want 0", mem_req); end
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    exp_t e;
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    sb_q.push_back('{is_lsu: 1'b0, rdata: model_rdata(32'h100)});
    #1;
    n_cmp++; if (stall_F !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_c0 got %b want 1", stall_F); end
    @(negedge clk);
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_funct3} !== {1'b1, 1'b0, 32'h100, 3'b010})
      begin n_bad++; $display("FAIL fetch_bus_c1 got req=%b we=%b addr=%h f3=%b want 1 0 00000100 010", mem_req, mem_we, mem_addr, mem_funct3); end
    n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ack got %b want 0", if_ack); end
    @(negedge clk);
    n_cmp++; if (if_ack !== 1'b1) begin n_bad++; $display("FAIL fetch_ack_c2 got %b want 1", if_ack); end
    if (if_ack === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++; if (if_rdata !== e.rdata) begin n_bad++; $display("FAIL fetch_rdata got %h want %h", if_rdata, e.rdata); end
    end
    n_cmp++; if ({mem_req, stall_F} !== 2'b00) begin n_bad++; $display("FAIL fetch_c2_req_stall got %b want 00", {mem_req, stall_F}); end
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({if_ack, if_rdata} !== {1'b0, 32'h13}) begin n_bad++; $display("FAIL fetch_hold got ack=%b rdata=%h want 0 00000013", if_ack, if_rdata); end
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL fetch_pending got %0d want 0", sb_q.size()); end
    sb_q.delete();
    $display("test_single_fetch done");
  endtask

  task automatic test_tie_after_reset();
    exp_t e;
    int acks = 0, lsu_ack_cyc = -1, if_grant_cyc = -1, first_grant = -1;
    logic prev_req = 1'b0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h300;
    lsu_re = 1'b1; lsu_addr = 32'h400; lsu_funct3 = 3'b100;
    sb_q.push_back('{is_lsu: 1'b1, rdata: model_rdata(32'h400)});
    sb_q.push_back('{is_lsu: 1'b0, rdata: model_rdata(32'h300)});
    for (int c = 1; c <= 30 && acks < 2; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (first_grant < 0) first_grant = (mem_addr == 32'h400) ? 1 : 0;
        if (mem_addr == 32'h300) if_grant_cyc = c;
      end
      prev_req = mem_req;
      if (if_ack || lsu_ack) begin
        n_cmp++; if (if_ack && lsu_ack) begin n_bad++; $display("FAIL tie_double_ack got 11 want one-hot"); end
        if (sb_q.size() == 0) begin
          n_bad++; $display("FAIL tie_extra_ack got ack want none");
        end else begin
          e = sb_q.pop_front();
          n_cmp++; if ({lsu_ack, (lsu_ack ? lsu_rdata : if_rdata)} !== {e.is_lsu, e.rdata})
            begin n_bad++; $display("FAIL tie_resp got lsu=%b data=%h want lsu=%b data=%h", lsu_ack, lsu_ack ? lsu_rdata : if_rdata, e.is_lsu, e.rdata); end
        end
        if (lsu_ack) begin lsu_ack_cyc = c; lsu_re = 1'b0; end
        else if_req = 1'b0;
        acks++;
      end
    end
    if_req = 1'b0; lsu_re = 1'b0;
    n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL tie_ack_count got %0d want 2", acks); end
    n_cmp++; if (first_grant != 1) begin n_bad++; $display("FAIL tie_first_grant got %0d want 1(lsu)", first_grant); end
    n_cmp++; if (if_grant_cyc != lsu_ack_cyc + 2) begin n_bad++; $display("FAIL tie_if_grant_cycle got %0d want %0d", if_grant_cyc, lsu_ack_cyc + 2); end
    sb_q.delete();
    $display("test_tie_after_reset done");
  endtask

  task automatic test_alternation();
    exp_t e;
    int acks = 0, grants = 0;
    logic prev_req = 1'b0;
    logic exp_lsu;
    do_reset();
    mem_wait = 1;
    lsu_re = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h600; lsu_wdata = 32'h1234_5678; lsu_funct3 = 3'b001;
    if_req = 1'b1; if_addr = 32'h700;
    for (int k = 0; k < 4; k++)
      sb_q.push_back('{is_lsu: (k % 2 == 0), rdata: model_rdata((k % 2 == 0) ? 32'h600 : 32'h700)});
    for (int c = 1; c <= 60 && acks < 4; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        exp_lsu = (grants % 2 == 0);
        n_cmp++; if ({mem_addr, mem_we} !== {(exp_lsu ? 32'h600 : 32'h700), exp_lsu})
          begin n_bad++; $display("FAIL alt_grant%0d got addr=%h we=%b want addr=%h we=%b", grants, mem_addr, mem_we, exp_lsu ? 32'h600 : 32'h700, exp_lsu); end
        grants++;
      end
      prev_req = mem_req;
      if (if_ack || lsu_ack) begin
        if (sb_q.size() == 0) begin
          n_bad++; $display("FAIL alt_extra_ack got ack want none");
        end else begin
          e = sb_q.pop_front();
          n_cmp++; if ({lsu_ack, if_ack, (lsu_ack ? lsu_rdata : if_rdata)} !== {e.is_lsu, ~e.is_lsu, e.rdata})
            begin n_bad++; $display("FAIL alt_resp%0d got lsu=%b if=%b want lsu=%b", acks, lsu_ack, if_ack, e.is_lsu); end
        end
        acks++;
        if (acks == 4) begin if_req = 1'b0; lsu_re = 1'b0; lsu_we = 1'b0; end
      end
    end
    if_req = 1'b0; lsu_re = 1'b0; lsu_we = 1'b0;
    n_cmp++; if (acks != 4) begin n_bad++; $display("FAIL alt_ack_count got %0d want 4", acks); end
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL alt_quiet got %b want 0", mem_req); end
    sb_q.delete();
    $display("test_alternation done");
  endtask

  task automatic test_store_wait();
    exp_t e;
    int hi = 0;
    logic done = 1'b0;
    do_reset();
    mem_wait = 4;
    lsu_we = 1'b1; lsu_addr = 32'h2000; lsu_wdata = 32'hDEAD_BEEF; lsu_funct3 = 3'b010;
    sb_q.push_back('{is_lsu: 1'b1, rdata: model_rdata(32'h2000)});
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_req) begin
        hi++;
        n_cmp++; if ({mem_we, mem_addr, mem_wdata, mem_funct3} !== {1'b1, 32'h2000, 32'hDEAD_BEEF, 3'b010})
          begin n_bad++; $display("FAIL store_fields c%0d got we=%b addr=%h wdata=%h f3=%b", c, mem_we, mem_addr, mem_wdata, mem_funct3); end
      end
      if (!lsu_ack) begin
        n_cmp++; if (stall_M !== 1'b1) begin n_bad++; $display("FAIL store_stall c%0d got %b want 1", c, stall_M); end
      end else begin
        e = sb_q.pop_front();
        n_cmp++; if (lsu_rdata !== e.rdata) begin n_bad++; $display("FAIL store_rdata got %h want %h", lsu_rdata, e.rdata); end
        n_cmp++; if (stall_M !== 1'b0) begin n_bad++; $display("FAIL store_stall_ack got %b want 0", stall_M); end
        lsu_we = 1'b0; done = 1'b1;
        break;
      end
    end
    lsu_we = 1'b0; mem_wait = 0;
    n_cmp++; if (!done) begin n_bad++; $display("FAIL store_timeout got no ack want ack"); end
    n_cmp++; if (hi != 5) begin n_bad++; $display("FAIL store_req_cycles got %0d want 5", hi); end
    sb_q.delete();
    $display("test_store_wait done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_wait = 100;
    lsu_we = 1'b1; lsu_addr = 32'h3000; lsu_wdata = 32'hCAFE_F00D; lsu_funct3 = 3'b010;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_bus got %b want 1", mem_req); end
    @(negedge clk);
    reset_n = 1'b0; lsu_we = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_req, lsu_ack} !== 2'b00) begin n_bad++; $display("FAIL rmid_abandon got %b want 00", {mem_req, lsu_ack}); end
    reset_n = 1'b1; stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if ({mem_req, lsu_ack, if_ack, lsu_rdata} !== {3'b000, 32'h0})
        begin n_bad++; $display("FAIL rmid_late_ack c%0d got req=%b lack=%b iack=%b lrd=%h want 0 0 0 0", c, mem_req, lsu_ack, if_ack, lsu_rdata); end
      @(negedge clk);
    end
    mem_wait = 0;
    $display("test_reset_mid done");
  endtask

  task automatic test_held_request();
    exp_t e;
    int acks = 0;
    int ack_cyc[2] = '{-1, -1};
    logic mr[16];
    do_reset();
    for (int i = 0; i < 16; i++) mr[i] = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    sb_q.push_back('{is_lsu: 1'b0, rdata: model_rdata(32'h500)});
    sb_q.push_back('{is_lsu: 1'b0, rdata: model_rdata(32'h500)});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      mr[c] = mem_req;
      if (if_ack) begin
        e = sb_q.pop_front();
        n_cmp++; if (if_rdata !== e.rdata) begin n_bad++; $display("FAIL held_rdata%0d got %h want %h", acks, if_rdata, e.rdata); end
        ack_cyc[acks] = c;
        acks++;
        if (acks == 2) begin if_req = 1'b0; break; end
      end
    end
    if_req = 1'b0;
    n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL held_ack_count got %0d want 2", acks); end
    n_cmp++; if ({mr[3], mr[4]} !== 2'b01) begin n_bad++; $display("FAIL held_regrant got c3=%b c4=%b want 0 1", mr[3], mr[4]); end
    n_cmp++; if (ack_cyc[0] != 2 || ack_cyc[1] != 5) begin n_bad++; $display("FAIL held_ack_cycles got %0d,%0d want 2,5", ack_cyc[0], ack_cyc[1]); end
    sb_q.delete();
    $display("test_held_request done");
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; lsu_re = 1'b0; lsu_we = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_funct3 = 3'b000;
    test_reset();
    test_single_fetch();
    test_tie_after_reset();
    test_alternation();
    test_store_wait();
    test_reset_mid();
    test_held_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
